// File: rtl/action_decoder_pkg.sv
// rtl/action_decoder_pkg.sv - action codes, command op encoding, FSM states and move directions
package action_decoder_pkg;

  // 3-bit click-action codes shared with the button encoder
  localparam logic [2:0] ACT_NONE     = 3'b000;
  localparam logic [2:0] ACT_REVEAL   = 3'b001;
  localparam logic [2:0] ACT_FLAG     = 3'b010;
  localparam logic [2:0] ACT_RESERVED = 3'b011;
  localparam logic [2:0] ACT_UP       = 3'b100;
  localparam logic [2:0] ACT_RIGHT    = 3'b101;
  localparam logic [2:0] ACT_DOWN     = 3'b110;
  localparam logic [2:0] ACT_LEFT     = 3'b111;

  // Command op driven to the board engine
  localparam logic CMD_OP_REVEAL = 1'b0;
  localparam logic CMD_OP_FLAG   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_ACK     = 2'b10,
    ST_RELEASE = 2'b11
  } state_e;

  // Move direction is the low two bits of a move code (bit 2 set)
  typedef enum logic [1:0] {
    DIR_U = 2'b00,
    DIR_R = 2'b01,
    DIR_D = 2'b10,
    DIR_L = 2'b11
  } dir_e;

  function automatic logic is_move(input logic [2:0] code);
    return code[2];
  endfunction

  function automatic logic is_cmd(input logic [2:0] code);
    return (code == ACT_REVEAL) || (code == ACT_FLAG);
  endfunction

endpackage

// File: rtl/action_decoder_if.sv
// rtl/action_decoder_if.sv - reveal/flag command handshake towards the board engine
interface action_decoder_if #(
  parameter int ROW_W = 3,
  parameter int COL_W = 3
);

  logic             cmd_valid;
  logic             cmd_op;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_row,
    output cmd_col,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_row,
    input  cmd_col,
    output cmd_ready
  );

endinterface

// File: rtl/action_decoder_cursor_step.sv
// rtl/action_decoder_cursor_step.sv - next cursor position for one move; CURSOR_WRAP_EN selects wrap vs clamp
module action_decoder_cursor_step
  import action_decoder_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] col_i,
  input  dir_e             dir_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o
);

`ifdef CURSOR_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  // Edges are explicit compares so non-power-of-two boards behave correctly
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  // Step one cell in the requested direction; at an edge either wrap or hold
  always_comb begin
    row_o = row_i;
    col_o = col_i;
    case (dir_i)
      DIR_U: row_o = (row_i == '0)      ? (WRAP ? ROW_MAX : row_i) : row_i - ROW_ONE;
      DIR_D: row_o = (row_i == ROW_MAX) ? (WRAP ? '0 : row_i)      : row_i + ROW_ONE;
      DIR_L: col_o = (col_i == '0)      ? (WRAP ? COL_MAX : col_i) : col_i - COL_ONE;
      DIR_R: col_o = (col_i == COL_MAX) ? (WRAP ? '0 : col_i)      : col_i + COL_ONE;
      default: begin
        row_o = row_i;
        col_o = col_i;
      end
    endcase
  end

endmodule

// File: rtl/action_decoder.sv
// rtl/action_decoder.sv - consumes click actions, moves the cursor or issues reveal/flag, then acks; CURSOR_WRAP_EN selects edge wrap
module action_decoder
  import action_decoder_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int ROW_W = $clog2(ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic               clk,
  input  logic               clear_n,
  input  logic [2:0]         action_in,
  input  logic               game_over,
  action_decoder_if.master   cmd,
  output logic               ack,
  output logic [ROW_W-1:0]   cursor_row,
  output logic [COL_W-1:0]   cursor_col
);

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             valid_q, valid_d;
  logic             op_q, op_d;
  logic             ack_q;
  logic [ROW_W-1:0] step_row;
  logic [COL_W-1:0] step_col;

  action_decoder_cursor_step #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_step (
    .row_i (row_q),
    .col_i (col_q),
    .dir_i (dir_e'(action_in[1:0])),
    .row_o (step_row),
    .col_o (step_col)
  );

  // Next state: cursor only changes from IDLE, so it is frozen during a command
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (action_in != ACT_NONE) begin
          if (is_move(action_in)) begin
            row_d   = step_row;
            col_d   = step_col;
            state_d = ST_ACK;
          end else if (is_cmd(action_in) && !game_over) begin
            valid_d = 1'b1;
            op_d    = (action_in == ACT_FLAG) ? CMD_OP_FLAG : CMD_OP_REVEAL;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ISSUE: begin
        // game_over arriving now does not withdraw an issued command
        if (valid_q && cmd.cmd_ready) begin
          valid_d = 1'b0;
          state_d = ST_ACK;
        end
      end
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (action_in == ACT_NONE) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State and output registers; ack is registered from the next state so it is high exactly in ACK
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      op_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      ack_q   <= (state_d == ST_ACK);
    end
  end

  assign ack           = ack_q;
  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_op    = op_q;
  assign cmd.cmd_row   = row_q;
  assign cmd.cmd_col   = col_q;

endmodule

// File: tb/tb_action_decoder.sv
// tb/tb_action_decoder.sv - directed and randomized checks of action_decoder against a cursor/transaction model
module tb_action_decoder;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clear_n;
  logic [2:0]       action_in;
  logic             game_over;
  logic             ack;
  logic [ROW_W-1:0] cursor_row;
  logic [COL_W-1:0] cursor_col;

  int n_cmp = 0;
  int n_bad = 0;
  int mr = 0;
  int mc = 0;

  always #5 clk = ~clk;

  action_decoder_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  action_decoder #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .action_in  (action_in),
    .game_over  (game_over),
    .cmd        (bus),
    .ack        (ack),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference cursor: plain arithmetic over the board bounds
  task automatic model_move(input logic [2:0] code);
    case (code)
      3'b100: mr = (mr == 0)        ? (WRAP ? ROWS - 1 : 0) : mr - 1;
      3'b110: mr = (mr == ROWS - 1) ? (WRAP ? 0 : mr)       : mr + 1;
      3'b111: mc = (mc == 0)        ? (WRAP ? COLS - 1 : 0) : mc - 1;
      3'b101: mc = (mc == COLS - 1) ? (WRAP ? 0 : mc)       : mc + 1;
      default: ;
    endcase
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_row"}, cursor_row, mr);
    check({tag, "_col"}, cursor_col, mc);
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    action_in = 3'b000;
    game_over = 1'b0;
    bus.cmd_ready = 1'b0;
    step();
    step();
    mr = 0;
    mc = 0;
    check("rst_ack", ack, 0);
    check("rst_valid", bus.cmd_valid, 0);
    check("rst_op", bus.cmd_op, 0);
    check_cursor("rst");
    clear_n = 1'b1;
  endtask

  // One complete action transaction: present code, optional command handshake,
  // single ack, code held for hold_n extra cycles, then released to 000.
  task automatic act(input logic [2:0] code, input logic go, input int wait_n, input int hold_n);
    bit cmd_expected;
    cmd_expected = ((code == 3'b001) || (code == 3'b010)) && !go;
    action_in = code;
    game_over = go;
    bus.cmd_ready = 1'b0;
    step();
    if (cmd_expected) begin
      check("cmd_rise_valid", bus.cmd_valid, 1);
      check("cmd_rise_op", bus.cmd_op, code[1]);
      check("cmd_rise_row", bus.cmd_row, mr);
      check("cmd_rise_col", bus.cmd_col, mc);
      check("cmd_rise_ack", ack, 0);
      for (int i = 0; i < wait_n; i++) begin
        game_over = 1'($urandom_range(0, 1));
        step();
        check("cmd_hold_valid", bus.cmd_valid, 1);
        check("cmd_hold_op", bus.cmd_op, code[1]);
        check("cmd_hold_row", bus.cmd_row, mr);
        check("cmd_hold_col", bus.cmd_col, mc);
        check("cmd_hold_ack", ack, 0);
      end
      bus.cmd_ready = 1'b1;
      step();
      bus.cmd_ready = 1'b0;
      check("cmd_done_valid", bus.cmd_valid, 0);
      check("cmd_done_ack", ack, 1);
    end else begin
      if (code[2]) model_move(code);
      check("act_ack", ack, 1);
      check("act_valid", bus.cmd_valid, 0);
    end
    check_cursor("act_cursor");
    for (int i = 0; i <= hold_n; i++) begin
      step();
      check("hold_ack", ack, 0);
      check("hold_valid", bus.cmd_valid, 0);
      check_cursor("hold_cursor");
    end
    action_in = 3'b000;
    game_over = 1'b0;
    step();
    check("release_ack", ack, 0);
    check_cursor("release_cursor");
  endtask

  initial begin
    logic [2:0] code;

    // Reset state
    do_reset();

    // Down held for 2 cycles then released: one move, one ack
    act(3'b110, 1'b0, 0, 1);
    check("t1_row", cursor_row, 1);
    check("t1_col", cursor_col, 0);

    // Up at the top edge: wrap or clamp, ack either way
    do_reset();
    act(3'b100, 1'b0, 0, 0);
    check("t2_row", cursor_row, WRAP ? ROWS - 1 : 0);

    // Walk to (3,5) then flag with a 4-cycle backpressure
    do_reset();
    for (int i = 0; i < 3; i++) act(3'b110, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) act(3'b101, 1'b0, 0, 0);
    check("t3_row", cursor_row, 3);
    check("t3_col", cursor_col, 5);
    act(3'b010, 1'b0, 4, 0);

    // Reveal while game over and the reserved code: ack only
    act(3'b001, 1'b1, 0, 0);
    act(3'b011, 1'b0, 0, 0);
    check("t4_row", cursor_row, 3);

    // Reset in the middle of an issued command
    action_in = 3'b001;
    game_over = 1'b0;
    step();
    check("t5_pre_valid", bus.cmd_valid, 1);
    clear_n = 1'b0;
    step();
    mr = 0;
    mc = 0;
    check("t5_valid", bus.cmd_valid, 0);
    check("t5_ack", ack, 0);
    check("t5_op", bus.cmd_op, 0);
    check_cursor("t5_cursor");
    clear_n = 1'b1;
    action_in = 3'b000;
    step();
    act(3'b101, 1'b0, 0, 0);
    check("t5_after_col", cursor_col, 1);

    // Code held 10 cycles past ack: single effect
    act(3'b101, 1'b0, 0, 10);
    check("t6_col", cursor_col, 2);

    // Randomized sequence of actions
    for (int n = 0; n < 200; n++) begin
      code = 3'($urandom_range(0, 7));
      if (code == 3'b000) begin
        action_in = 3'b000;
        step();
        check("rnd_idle_ack", ack, 0);
        check("rnd_idle_valid", bus.cmd_valid, 0);
        check_cursor("rnd_idle_cursor");
      end else begin
        act(code, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
